run_control: RTL and testbench
==============================

Name: run_control

Overview:
- Sequences the CPU clock-enable (`tick`) for the board top: free-running at a prescaled rate (RUN), single-step on a debounced push button (STEP), or stopped on a halt request (HALTED).
- Replaces a bare prescaler slow clock with a one-cycle enable in the system clock domain.
- Reports its state for LED display.

Parameters:
- RATIO, 50000000, system clock cycles per tick in RUN; legal range 1..2^32-1.
- DEBOUNCE, 1000000, cycles `step_button` must be stable before the debounced level changes; legal range 1..2^32-1.

Ports:
- clock  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset; all flops clear on assertion, release is synchronous to `clock`.
- mode_run  in  1  raw switch level, asynchronous; 1 = free-run requested.
- step_button  in  1  raw push button, asynchronous, bouncy; 1 = pressed.
- halt_request  in  1  synchronous one-cycle or level request from the CPU to stop.
- clear_halt  in  1  synchronous pulse; leaves HALTED.
- tick  out  1  one-cycle CPU clock enable.
- state  out  2  current state encoding: IDLE=00, RUN=01, STEP=10, HALTED=11.
- tick_count  out  16  number of ticks issued; wraps.

Behaviour:
- Reset values:
  - state=IDLE, tick=0, tick_count=0.
  - Prescale counter=0.
  - Synchronizers and debounced level=0.
- Input synchronization:
  - `mode_run` and `step_button` each pass through a 2-flop synchronizer.
  - `halt_request` and `clear_halt` are used directly.
- Debounce:
  - The counter resets whenever the synced button differs from the debounced level.
  - When the counter reaches DEBOUNCE-1 with the level still differing, the debounced level flips and the counter clears.
  - `step_event` is a 1-cycle pulse on the debounced 0->1 edge.
  - Raw press to `step_event` = 2 (sync) + DEBOUNCE cycles.
- Transitions (evaluated each cycle, priority top-down within a state):
  - IDLE:
    - halt_request -> HALTED.
    - else mode_run_s -> RUN, counter=0.
    - else step_event -> STEP and fire.
  - RUN:
    - halt_request -> HALTED, no fire, counter=0.
    - else !mode_run_s -> IDLE, counter=0.
    - else if counter==RATIO-1: fire, counter=0.
    - else counter+1.
  - STEP:
    - halt_request -> HALTED.
    - else debounced level 0 (button released) -> IDLE.
    - Holding the button never produces a second tick.
  - HALTED:
    - clear_halt -> IDLE.
    - halt_request ignored; mode_run and step_event ignored and not queued.
- Tick timing:
  - tick is registered: tick=1 in the cycle after a fire decision, else 0.
  - In RUN, the first tick is high RATIO cycles after the state register shows RUN; the period is exactly RATIO thereafter.
  - RATIO=1 gives tick high every cycle while in RUN.
  - A tick already registered is still emitted in the cycle a halt is taken (no retraction).
- tick_count:
  - Increments on every cycle tick=1.
  - 16'hFFFF wraps to 0.
  - Not cleared by clear_halt.
- Simultaneous events:
  - halt_request wins over everything except HALTED/clear_halt.
  - clear_halt and halt_request together in HALTED -> IDLE.
  - step_event while in RUN is ignored.
- Reset mid-operation: immediate return to reset values; any pending debounce or prescale progress is discarded.

Decomposition:
- Package run_control_pkg:
  - `state_t` enum (2-bit, encodings above).
  - Localparam width helper for the counter sizes ($clog2 of the parameters, minimum 1).
- Sub-module `debouncer` (parameter DEBOUNCE):
  - Holds the 2-flop synchronizer and the stability counter.
  - Outputs the debounced level and the rise pulse.
- `mode_run` uses a plain 2-flop synchronizer instantiated in run_control.

Test Plan (RATIO=2, DEBOUNCE=4, 10 ns clock, reset low first 10 ns):
1. Reset release with all inputs 0 -> state=00, tick=0, tick_count=0 for 20 cycles.
2. mode_run=1 -> state=01 three cycles later; tick pulses every 2 cycles; after 10 ticks tick_count=10. mode_run=0 -> state=00, no further ticks.
3. step_button held 1 for 30 cycles with 3 bounce glitches of 2 cycles each at the start:
   - exactly one tick, 2+4 cycles after the last glitch;
   - state=10 while held, 00 after release plus 6 cycles;
   - tick_count +1.
4. In RUN, pulse halt_request:
   - state=11 next cycle; at most the one already-registered tick;
   - mode_run=1 and button presses give no ticks;
   - clear_halt -> IDLE, then RUN resumes.
5. Preload-style run of 65536 ticks (RATIO=1) -> tick_count wraps to 0.
6. Assert n_reset low mid-RUN and mid-debounce:
   - all outputs return to reset values asynchronously;
   - after release, no stale tick or step_event.

Source files
------------

// File: rtl/run_control_pkg.sv
// run_control_pkg: shared state encoding and counter-width helper for run_control.
package run_control_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;
  function automatic int cnt_width(input longint unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/run_control_debouncer.sv
// debouncer: synchronizes a bouncy button and emits a stable level plus a one-cycle rise pulse.
module debouncer
  import run_control_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic i_clock,
  input  logic i_n_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);
  localparam int CW = cnt_width(DEBOUNCE);
  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  // Level only flips after DEBOUNCE consecutive cycles of disagreement.
  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      if (r_s2 == r_level) r_cnt <= '0;
      else if (r_cnt == CW'(DEBOUNCE - 1)) begin
        r_level <= r_s2;
        r_rise  <= r_s2;
        r_cnt   <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  end
  assign o_level = r_level;
  assign o_rise  = r_rise;
endmodule

// File: rtl/run_control.sv
// run_control: sequences the CPU clock-enable tick in run, single-step and halted modes.
module run_control
  import run_control_pkg::*;
#(
  parameter int unsigned RATIO    = 50000000,
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        mode_run,
  input  logic        step_button,
  input  logic        halt_request,
  input  logic        clear_halt,
  output logic        tick,
  output logic [1:0]  state,
  output logic [15:0] tick_count
);
  localparam int CW = cnt_width(RATIO);
  logic          r_mode_s1;
  logic          r_mode_s2;
  logic          w_level;
  logic          w_step_event;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [15:0]   r_tick_count;
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
    end else begin
      r_mode_s1 <= mode_run;
      r_mode_s2 <= r_mode_s1;
    end
  end
  debouncer #(.DEBOUNCE(DEBOUNCE)) u_debouncer (
    .i_clock  (clock),
    .i_n_reset(n_reset),
    .i_raw    (step_button),
    .o_level  (w_level),
    .o_rise   (w_step_event)
  );
  // A fire decision sets r_tick, so the enable appears one cycle later and is never retracted.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_tick <= 1'b0;
      if (r_tick) r_tick_count <= r_tick_count + 16'd1;
      case (r_state)
        IDLE:
          if (halt_request) r_state <= HALTED;
          else if (r_mode_s2) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else if (w_step_event) begin
            r_state <= STEP;
            r_tick  <= 1'b1;
          end
        RUN:
          if (halt_request) begin
            r_state <= HALTED;
            r_cnt   <= '0;
          end else if (!r_mode_s2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(RATIO - 1)) begin
            r_tick <= 1'b1;
            r_cnt  <= '0;
          end else r_cnt <= r_cnt + CW'(1);
        STEP:
          if (halt_request) r_state <= HALTED;
          else if (!w_level) r_state <= IDLE;
        HALTED:
          if (clear_halt) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign tick       = r_tick;
  assign state      = r_state;
  assign tick_count = r_tick_count;
endmodule

// File: tb/tb_run_control.sv
// tb_run_control: directed table and sequence checks of run_control (RATIO=2, DEBOUNCE=4) plus a RATIO=1 wrap instance.
module tb_run_control;
  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic        mode_run = 1'b0;
  logic        step_button = 1'b0;
  logic        halt_request = 1'b0;
  logic        clear_halt = 1'b0;
  logic        tick;
  logic [1:0]  state;
  logic [15:0] tick_count;
  logic        w_mode = 1'b0;
  logic        w_tick;
  logic [1:0]  w_state;
  logic [15:0] w_count;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_cnt;
  typedef struct {
    logic       mode;
    logic       btn;
    logic       halt;
    logic       clr;
    logic [1:0] st;
    logic       tk;
  } vec_t;
  vec_t tbl [21];
  always #5 clock = ~clock;
  run_control #(.RATIO(2), .DEBOUNCE(4)) dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .mode_run    (mode_run),
    .step_button (step_button),
    .halt_request(halt_request),
    .clear_halt  (clear_halt),
    .tick        (tick),
    .state       (state),
    .tick_count  (tick_count)
  );
  run_control #(.RATIO(1), .DEBOUNCE(4)) u_wrap (
    .clock       (clock),
    .n_reset     (n_reset),
    .mode_run    (w_mode),
    .step_button (1'b0),
    .halt_request(1'b0),
    .clear_halt  (1'b0),
    .tick        (w_tick),
    .state       (w_state),
    .tick_count  (w_count)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  initial begin
    int ntick;
    int tick_at;
    bit found;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    #10 n_reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("reset_state", state, 0);
      chk("reset_tick", tick, 0);
      chk("reset_count", tick_count, 0);
    end
    mode_run = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      chk("run_state", state, (c >= 3 && c <= 24) ? 1 : 0);
      chk("run_tick", tick, (c % 2 == 1 && c >= 5 && c <= 23) ? 1 : 0);
      if (c == 22) mode_run = 1'b0;
    end
    chk("run_count10", tick_count, 10);
    exp_cnt = 10;
    for (int i = 0; i < 21; i++) begin
      mode_run = tbl[i].mode;
      step_button = tbl[i].btn;
      halt_request = tbl[i].halt;
      clear_halt = tbl[i].clr;
      @(negedge clock);
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tk);
      chk($sformatf("tbl%0d_count", i), tick_count, exp_cnt);
      if (tbl[i].tk) exp_cnt++;
    end
    {mode_run, step_button, halt_request, clear_halt} = 4'b0;
    repeat (4) @(negedge clock);
    ntick = 0;
    tick_at = -1;
    for (int k = 0; k < 3; k++) begin
      step_button = 1'b1;
      repeat (2) begin @(negedge clock); if (tick) ntick++; end
      step_button = 1'b0;
      repeat (2) begin @(negedge clock); if (tick) ntick++; end
    end
    step_button = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (tick) begin ntick++; tick_at = c; end
      if (c >= 7 && c <= 36) chk("step_held_state", state, 2);
      if (c >= 38) chk("step_release_state", state, 0);
      if (c == 30) step_button = 1'b0;
    end
    chk("step_one_tick", ntick, 1);
    chk("step_tick_time", (tick_at >= 6 && tick_at <= 7) ? 1 : 0, 1);
    exp_cnt++;
    chk("step_count", tick_count, exp_cnt);
    halt_request = 1'b1;
    @(negedge clock);
    halt_request = 1'b0;
    chk("halt_from_idle", state, 3);
    mode_run = 1'b1;
    step_button = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      chk("halted_state", state, 3);
      chk("halted_tick", tick, 0);
      if (c == 12) step_button = 1'b0;
    end
    chk("halted_count", tick_count, exp_cnt);
    clear_halt = 1'b1;
    @(negedge clock);
    clear_halt = 1'b0;
    chk("clear_to_idle", state, 0);
    @(negedge clock);
    chk("resume_run", state, 1);
    @(negedge clock);
    chk("resume_tick0", tick, 0);
    mode_run = 1'b0;
    @(negedge clock);
    chk("resume_tick1", tick, 1);
    exp_cnt++;
    repeat (6) @(negedge clock);
    chk("resume_idle", state, 0);
    chk("resume_count", tick_count, exp_cnt);
    w_mode = 1'b1;
    repeat (3) @(negedge clock);
    chk("wrap_run", w_state, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("wrap_every_cycle", w_tick, 1);
    end
    found = 1'b0;
    for (int c = 0; c < 70000 && !found; c++) begin
      @(negedge clock);
      if (w_count == 16'hFFFF) found = 1'b1;
    end
    chk("wrap_reach_ffff", found, 1);
    @(negedge clock);
    chk("wrap_zero", w_count, 0);
    chk("wrap_tick", w_tick, 1);
    @(negedge clock);
    chk("wrap_one", w_count, 1);
    w_mode = 1'b0;
    mode_run = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      if (state == 2'd1 && tick) found = 1'b1;
    end
    chk("rst_reach_run_tick", found, 1);
    step_button = 1'b1;
    repeat (3) @(negedge clock);
    #2 n_reset = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_count", tick_count, 0);
    mode_run = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      chk("post_rst_tick", tick, (c == 7) ? 1 : 0);
      chk("post_rst_state", state, (c == 7) ? 2 : 0);
    end
    step_button = 1'b0;
    repeat (10) @(negedge clock);
    chk("post_rst_idle", state, 0);
    chk("post_rst_count", tick_count, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
